// File: rtl/configure.sv
// System configuration: memory map types and the default router region map.
package configure;

  localparam int unsigned RouterNslv = 4;

  typedef logic [RouterNslv-1:0][31:0] router_map_t;

  // Index order: 0 rom, 1 uart, 2 clint, 3 avl (element 0 is the rightmost word).
  localparam router_map_t router_base = {
    32'h8000_0000, 32'h0200_0000, 32'h1000_0000, 32'h0000_0000
  };
  localparam router_map_t router_top = {
    32'h9000_0000, 32'h0201_0000, 32'h1000_1000, 32'h0001_0000
  };

  typedef enum logic [1:0] {StIdle, StBusy, StErr} router_state_e;

endpackage

// File: rtl/mem_router_decode.sv
// Priority address decoder: lowest-index region containing addr wins.
module mem_router_decode #(
  parameter int unsigned            NSLV = 4,
  parameter int unsigned            IdxW = 2,
  parameter logic [NSLV-1:0][31:0]  BASE = '0,
  parameter logic [NSLV-1:0][31:0]  TOP  = '0
) (
  input  logic [31:0]     addr,
  output logic            hit,
  output logic [IdxW-1:0] index
);

  // Scan from the top so the lowest matching index is written last.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (addr >= BASE[i] && addr < TOP[i]) begin
        hit   = 1'b1;
        index = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_router.sv
// Routes single-outstanding memory requests to address-mapped slaves with
// decode-error, per-slave timeout and stale-slave tracking.
module mem_router
  import configure::*;
#(
  parameter int unsigned           NSLV    = 4,
  parameter int unsigned           TIMEOUT = 1023,
  parameter logic [NSLV-1:0][31:0] BASE    = configure::router_base,
  parameter logic [NSLV-1:0][31:0] TOP     = configure::router_top
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      memory_valid,
  input  logic                      memory_instr,
  input  logic [31:0]               memory_addr,
  input  logic [31:0]               memory_wdata,
  input  logic [3:0]                memory_wstrb,
  output logic [31:0]               memory_rdata,
  output logic                      memory_ready,
  output logic                      memory_error,
  output logic [NSLV-1:0]           slv_valid,
  output logic                      slv_instr,
  output logic [31:0]               slv_addr,
  output logic [31:0]               slv_wdata,
  output logic [3:0]                slv_wstrb,
  input  logic [NSLV-1:0][31:0]     slv_rdata,
  input  logic [NSLV-1:0]           slv_ready
);

  localparam int unsigned IdxW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW:0] TimeoutVal = (CntW + 1)'(TIMEOUT);

  router_state_e   state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NSLV-1:0] stale_q, stale_d;

  logic            hit;
  logic [IdxW-1:0] hit_idx;
  logic            sel_ready;
  logic [CntW:0]   cnt_inc;
  logic            timeout_fire;
  logic            accept;

  mem_router_decode #(
    .NSLV (NSLV),
    .IdxW (IdxW),
    .BASE (BASE),
    .TOP  (TOP)
  ) u_decode (
    .addr  (memory_addr),
    .hit   (hit),
    .index (hit_idx)
  );

  assign sel_ready = slv_ready[idx_q];
  assign cnt_inc   = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};
  // Ready wins over a timeout landing in the same cycle.
  assign timeout_fire = (TIMEOUT != 0) && (state_q == StBusy) && !sel_ready &&
                        (cnt_inc == TimeoutVal);
  assign accept = memory_valid && hit && !stale_q[hit_idx];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    stale_d = stale_q;
    // A late ready from any slave other than the one being waited on revives it.
    for (int j = 0; j < NSLV; j++) begin
      if (slv_ready[j] && !(state_q == StBusy && idx_q == IdxW'(j))) stale_d[j] = 1'b0;
    end
    case (state_q)
      StIdle: begin
        if (memory_valid) begin
          if (accept) begin
            idx_d   = hit_idx;
            cnt_d   = '0;
            state_d = StBusy;
          end else begin
            state_d = StErr;
          end
        end
      end
      StBusy: begin
        if (sel_ready) begin
          state_d = StIdle;
        end else if (timeout_fire) begin
          stale_d[idx_q] = 1'b1;
          state_d        = StIdle;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    memory_rdata = '0;
    memory_ready = 1'b0;
    memory_error = 1'b0;
    slv_valid    = '0;
    slv_instr    = 1'b0;
    slv_addr     = '0;
    slv_wdata    = '0;
    slv_wstrb    = '0;
    if (reset) begin
      slv_instr = memory_instr;
      slv_addr  = memory_addr - BASE[hit_idx];
      slv_wdata = memory_wdata;
      slv_wstrb = memory_wstrb;
      case (state_q)
        StIdle: if (accept) slv_valid[hit_idx] = 1'b1;
        StBusy: begin
          if (sel_ready) begin
            memory_ready = 1'b1;
            memory_rdata = slv_rdata[idx_q];
          end else if (timeout_fire) begin
            memory_ready = 1'b1;
            memory_error = 1'b1;
          end
        end
        StErr: begin
          memory_ready = 1'b1;
          memory_error = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_router.md
MEM_ROUTER -- requirements
Module: mem_router

Interface
REQ-001 SHALL have parameter NSLV, default 4: number of slave ports, range 1..16.
REQ-002 SHALL have parameter TIMEOUT, default 1023: cycles to wait for slave ready; 0 disables the timeout.
REQ-003 SHALL have parameter BASE, default configure::router_base: NSLV x 32-bit region base addresses.
REQ-004 SHALL have parameter TOP, default configure::router_top: NSLV x 32-bit exclusive region top addresses.
REQ-005 SHALL have port clock, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port memory_valid, input, 1 bit: one-cycle request pulse.
REQ-008 SHALL have ports memory_instr (input, 1 bit), memory_addr (input, 32 bits), memory_wdata (input, 32 bits) and memory_wstrb (input, 4 bits): request attributes; wstrb=0 means read.
REQ-009 SHALL have port memory_rdata, output, 32 bits: response data.
REQ-010 SHALL have port memory_ready, output, 1 bit: one-cycle response pulse.
REQ-011 SHALL have port memory_error, output, 1 bit: qualifies memory_ready as a decode, stale or timeout error.
REQ-012 SHALL have port slv_valid, output, NSLV bits: per-slave request pulse.
REQ-013 SHALL have ports slv_instr (output, 1 bit), slv_addr (output, 32 bits), slv_wdata (output, 32 bits) and slv_wstrb (output, 4 bits): shared request attributes; slv_addr is region-relative.
REQ-014 SHALL have port slv_rdata, input, NSLV x 32 bits: per-slave read data.
REQ-015 SHALL have port slv_ready, input, NSLV bits: per-slave response pulse.

Function
REQ-016 SHALL implement states IDLE, BUSY and ERR.
REQ-017 SHALL, in IDLE on memory_valid, select the lowest index i with BASE[i] <= addr < TOP[i]; overlapping regions resolve to the lowest index.
REQ-018 SHALL, on a hit to a non-stale slave, assert slv_valid[i] in the same cycle with slv_addr = memory_addr - BASE[i], latch i, clear the timeout counter and go to BUSY.
REQ-019 SHALL, on no hit or a hit to a stale slave, drive no slv_valid and go to ERR.
REQ-020 SHALL, in ERR, assert memory_ready=1, memory_error=1, memory_rdata=0 for exactly one cycle (one cycle after valid), then go to IDLE.
REQ-021 SHALL, in BUSY, pass slv_ready[i] and slv_rdata[i] of the latched slave combinationally with memory_error=0 and go to IDLE, adding zero latency.
REQ-022 SHALL ignore slv_ready from every non-latched slave.
REQ-023 SHALL, in BUSY, increment the counter each cycle without ready; when the counter equals TIMEOUT (TIMEOUT>0), assert memory_ready=1, memory_error=1, memory_rdata=0, set stale[i] and go to IDLE.
REQ-024 SHALL clear stale[j] on any slv_ready[j] while j is not the latched BUSY slave; that ready is not forwarded.
REQ-025 SHALL ignore memory_valid in BUSY and ERR (protocol violation; no state change).
REQ-026 SHALL, when slv_ready and the timeout occur in the same cycle, give ready priority: normal response, stale not set.
REQ-027 SHALL size the counter as $clog2(TIMEOUT+1) bits, saturating, never wrapping.
REQ-028 SHALL make memory_rdata=0 whenever memory_ready=0.

Reset
REQ-029 SHALL, on reset low, asynchronously force state=IDLE, counter=0, latched index=0, stale=0.
REQ-030 SHALL hold all outputs at 0 while reset is low.
REQ-031 SHALL abandon any BUSY transaction on reset mid-operation, with no response issued after release.

Structure
REQ-032 SHALL take the router_base/router_top array types and default maps (rom, uart, clint, avl) from package configure.
REQ-033 SHALL implement the priority range decode as sub-module mem_router_decode, combinational, outputs hit and index.

Verification
REQ-034 SHALL verify read at 0x8000_0010 with BASE[3]=0x8000_0000: slv_valid=4'b1000, slv_addr=0x10; slave ready after 3 cycles with 0xDEADBEEF gives memory_ready in the same cycle, rdata=0xDEADBEEF, error=0.
REQ-035 SHALL verify an unmapped address 0x4000_0000: no slv_valid; memory_ready=1, error=1, rdata=0 exactly one cycle later.
REQ-036 SHALL verify TIMEOUT=8 with slave 1 silent: error response in the 8th cycle after valid; a next request to slave 1 gives an ERR response; a late slv_ready[1] clears stale; the following request to slave 1 forwards.
REQ-037 SHALL verify overlapping regions 0 and 2 both containing 0x100: slave 0 selected.
REQ-038 SHALL verify spurious slv_ready[2] while BUSY on slave 0: not forwarded; the slave 0 response follows normally.
REQ-039 SHALL verify reset asserted in BUSY: outputs 0 immediately; a slave ready after release gives no memory_ready.
